// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Streams a configuration bitstream into a serial configuration flip-flop
// (ccff) chain. At the same time it captures the chain's previous contents
// as they fall out of the tail. Words arrive on a valid/ready handshake, MSB
// first. Each word is shifted out one bit per cycle while the chain is
// enabled. The final word may be partial; only its top bits are used.
//
// Ports
//   prog_clk   clock; all state changes on its rising edge
//   pReset     asynchronous active-low reset
//   start      one-cycle request to begin a load (sampled only in IDLE)
//   abort      ends an in-progress load; wins over every other transition
//   wr_data    bitstream word, MSB shifted first
//   wr_valid   wr_data is valid
//   wr_ready   the block accepts wr_data this cycle (FETCH only)
//   ccff_head  serial bit into the chain head
//   ccff_en    chain shift enable (SHIFT only)
//   ccff_tail  serial bit out of the chain tail
//   rd_data    readback word of old chain contents, MSB first
//   rd_valid   one-cycle strobe for rd_data, no backpressure
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a load completes
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 58,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  // Counters are sized to hold their full start value, so they never wrap.
  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  // Common width for comparing remaining against WORD_W. Either one may be
  // the wider of the two.
  localparam int CMP_W = (REM_W > WB_W) ? REM_W : WB_W;
  // Number of bits in the final word (1..WORD_W). The readback of that word
  // is left-justified by PAD positions.
  localparam int LAST_BITS = ((CHAIN_LEN - 1) % WORD_W) + 1;
  localparam int PAD       = WORD_W - LAST_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] shreg;       // word being shifted into the chain
  logic [WORD_W-1:0] rb;          // readback bits collected from the tail
  logic [WORD_W-1:0] rb_next;
  logic [REM_W-1:0]  remaining;   // chain bits still to be shifted
  logic [WB_W-1:0]   word_bits;   // bits left in the current word
  logic [WB_W-1:0]   word_len;    // min(WORD_W, remaining)
  logic              abort_hit;
  logic              last_of_word;
  logic              last_of_chain;

  assign abort_hit     = abort && (state != IDLE);
  assign last_of_word  = (word_bits == WB_W'(1));
  assign last_of_chain = (remaining == REM_W'(1));
  // Written as a shift/OR rather than a concatenation so that it also works
  // when WORD_W = 1.
  assign rb_next       = (rb << 1) | WORD_W'(ccff_tail);

  always_comb begin
    if (CMP_W'(remaining) >= CMP_W'(WORD_W)) begin
      word_len = WB_W'(WORD_W);
    end else begin
      word_len = WB_W'(remaining);
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top of the block keeps this purely
  // combinational; without it, paths that leave state_nxt unassigned would
  // infer a latch.
  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state_nxt = FETCH;
        FETCH: if (wr_valid) state_nxt = SHIFT;
        SHIFT: begin
          // word_bits reaches 0 on this edge.
          if (last_of_word) state_nxt = last_of_chain ? DONE : FETCH;
        end
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: shift register, readback, counters
  // -------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the FSM because the
  // readback word and counters must read as 0 while pReset is low. They are
  // a handful of flops, not a memory array.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shreg     <= '0;
      rb        <= '0;
      remaining <= '0;
      word_bits <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      // An abort freezes the datapath. The FSM returns to IDLE, and no
      // further readback strobe is issued.
      if (!abort_hit) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              remaining <= REM_W'(CHAIN_LEN);
              rb        <= '0;
            end
          end
          FETCH: begin
            if (wr_valid) begin
              shreg     <= wr_data;
              word_bits <= word_len;
            end
          end
          SHIFT: begin
            shreg     <= shreg << 1;
            rb        <= rb_next;
            remaining <= remaining - REM_W'(1);
            word_bits <= word_bits - WB_W'(1);
            if (last_of_word) begin
              rd_valid <= 1'b1;
              // Only the final word can be short. Shifting drops the stale
              // upper bits and zero-fills the bottom.
              rd_data  <= last_of_chain ? (rb_next << PAD) : rb_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (Moore, decoded from state only)
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ready  = 1'b0;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      FETCH: wr_ready = 1'b1;
      SHIFT: begin
        ccff_en   = 1'b1;
        ccff_head = shreg[WORD_W-1];
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Two instances: a 58-bit chain (dut_a) and an 8-bit chain (dut_e), both with
// 8-bit words. Each instance drives a behavioural chain (a bit vector) that
// shifts whenever ccff_en is high. Expected values come from the bitstream
// words and the chain snapshot taken before the load. The expected head
// sequence is the words read MSB-first. The expected readback is the old
// chain read tail-first and grouped into words. Timing follows from
// 1 + words + bits + stall cycles.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  localparam int W   = 8;
  localparam int N_A = 58;
  localparam int N_E = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic         pReset, start_a, start_e, abort, wr_valid;
  logic [W-1:0] wr_data;
  logic         a_ready, a_head, a_en, a_tail, a_rdv, a_busy, a_done;
  logic [W-1:0] a_rd;
  logic         e_ready, e_head, e_en, e_tail, e_rdv, e_busy, e_done;
  logic [W-1:0] e_rd;

  ccff_chain_loader #(.CHAIN_LEN(N_A), .WORD_W(W)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(a_ready),
    .ccff_head(a_head), .ccff_en(a_en), .ccff_tail(a_tail),
    .rd_data(a_rd), .rd_valid(a_rdv), .busy(a_busy), .done(a_done)
  );

  ccff_chain_loader #(.CHAIN_LEN(N_E), .WORD_W(W)) dut_e (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_e), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(e_ready),
    .ccff_head(e_head), .ccff_en(e_en), .ccff_tail(e_tail),
    .rd_data(e_rd), .rd_valid(e_rdv), .busy(e_busy), .done(e_done)
  );

  // Behavioural ccff chains
  logic [N_A-1:0] chain_a;
  logic [N_E-1:0] chain_e;
  logic           load_a, load_e;
  logic [N_A-1:0] load_val;

  always @(posedge prog_clk) begin
    if (load_a) chain_a <= load_val;
    else if (a_en) chain_a <= {chain_a[N_A-2:0], a_head};
    if (load_e) chain_e <= load_val[N_E-1:0];
    else if (e_en) chain_e <= {chain_e[N_E-2:0], e_head};
  end
  assign a_tail = chain_a[N_A-1];
  assign e_tail = chain_e[N_E-1];

  // View of the instance under test
  logic         sel;
  logic         cur_ready, cur_head, cur_en, cur_rdv, cur_busy, cur_done;
  logic [W-1:0] cur_rd;
  assign cur_ready = sel ? e_ready : a_ready;
  assign cur_head  = sel ? e_head  : a_head;
  assign cur_en    = sel ? e_en    : a_en;
  assign cur_rdv   = sel ? e_rdv   : a_rdv;
  assign cur_busy  = sel ? e_busy  : a_busy;
  assign cur_done  = sel ? e_done  : a_done;
  assign cur_rd    = sel ? e_rd    : a_rd;

  // Stimulus words and observations from the last load
  logic [W-1:0]   words [8];
  logic [N_A-1:0] snap;
  bit             head_q[$];
  logic [W-1:0]   rd_q[$];
  int             hs_cnt, done_cnt, done_cyc, idle_fetch, overlap, post_abort_bad;
  logic           busy_after;
  int             timeouts;
  int             vectors, miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic stream_bit(input int k);
    logic [W-1:0] wv;
    wv = words[k / W];
    return wv[W-1-(k % W)];
  endfunction

  // Chain preloaded so that the tail emits 0xA5 repeatedly, MSB first.
  function automatic logic [N_A-1:0] pattern_a5(input int n);
    logic [7:0]     p;
    logic [N_A-1:0] v;
    p = 8'hA5;
    v = '0;
    for (int k = 0; k < n; k++) v[n-1-k] = p[7-(k % 8)];
    return v;
  endfunction

  task automatic preload(input bit use_e, input logic [N_A-1:0] v);
    @(negedge prog_clk);
    load_val = v;
    load_a   = !use_e;
    load_e   = use_e;
    @(negedge prog_clk);
    load_a = 1'b0;
    load_e = 1'b0;
  endtask

  // Runs one load. Cycle 0 is the start cycle. Each cycle, the outputs are
  // sampled at the negedge, and then that cycle's inputs are driven.
  task automatic run_load(input bit use_e, input int stall_word, input int stall_len,
                          input bit rnd, input int abort_at, input int glitch_at);
    int c, wi, stalled, abort_cyc, end_cyc;
    bit fin;
    @(negedge prog_clk);
    sel  = use_e;
    snap = use_e ? N_A'(chain_e) : chain_a;
    head_q.delete();
    rd_q.delete();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; idle_fetch = 0; overlap = 0;
    post_abort_bad = 0; busy_after = 1'bx;
    wi = 0; stalled = 0; abort_cyc = -1; end_cyc = -1; fin = 1'b0;
    wr_data = words[0]; wr_valid = 1'b0; abort = 1'b0;
    if (use_e) start_e = 1'b1; else start_a = 1'b1;
    @(negedge prog_clk);
    start_a = 1'b0; start_e = 1'b0; c = 1;
    while (!fin) begin
      if (cur_ready && cur_en) overlap++;
      if (cur_en) head_q.push_back(cur_head);
      if (cur_rdv) rd_q.push_back(cur_rd);
      if (cur_done) begin done_cnt++; done_cyc = c; end
      if (abort_cyc >= 0 && c > abort_cyc &&
          (cur_busy || cur_en || cur_done || cur_rdv || cur_ready)) post_abort_bad++;
      if (c == end_cyc) begin
        busy_after = cur_busy;
        fin = 1'b1;
      end else if (c > 400) begin
        timeouts++;
        fin = 1'b1;
      end else begin
        start_a = 1'b0; start_e = 1'b0; abort = 1'b0;
        if (cur_en && head_q.size() == glitch_at + 1) begin
          if (use_e) start_e = 1'b1; else start_a = 1'b1;
        end
        if (cur_en && head_q.size() == abort_at + 1) begin
          abort = 1'b1; abort_cyc = c; end_cyc = c + 6;
        end
        wr_data = words[(wi < 8) ? wi : 7];
        if (cur_ready) begin
          if (rnd) wr_valid = ($urandom_range(0, 2) != 0);
          else if (wi == stall_word && stalled < stall_len) begin
            wr_valid = 1'b0; stalled++;
          end else wr_valid = 1'b1;
          if (wr_valid) begin hs_cnt++; wi++; end
          else idle_fetch++;
        end else begin
          wr_valid = 1'($urandom_range(0, 1));
        end
        if (cur_done) end_cyc = c + 1;
        @(negedge prog_clk);
        c++;
      end
    end
    start_a = 1'b0; start_e = 1'b0; abort = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic verify_full(input string tag, input bit use_e, input int n);
    int           nw;
    logic [63:0]  hv, sv, cv, chv;
    logic [W-1:0] ew, got;
    nw = (n + W - 1) / W;
    check({tag, "_en_cycles"}, 64'(head_q.size()), 64'(n));
    hv = '0; sv = '0; cv = '0;
    for (int k = 0; k < n; k++) begin
      if (k < head_q.size()) hv[k] = head_q[k];
      sv[k]     = stream_bit(k);
      cv[n-1-k] = stream_bit(k);
    end
    check({tag, "_head_seq"}, hv, sv);
    chv = use_e ? 64'(chain_e) : 64'(chain_a);
    check({tag, "_chain_contents"}, chv, cv);
    check({tag, "_handshakes"}, 64'(hs_cnt), 64'(nw));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(1 + nw + n + idle_fetch));
    check({tag, "_rd_count"}, 64'(rd_q.size()), 64'(nw));
    for (int j = 0; j < nw; j++) begin
      ew = '0;
      for (int k = j * W; k < n && k < (j + 1) * W; k++) ew[W-1-(k-j*W)] = snap[n-1-k];
      got = (j < rd_q.size()) ? rd_q[j] : 'x;
      check($sformatf("%s_rd_word%0d", tag, j), 64'(got), 64'(ew));
    end
    check({tag, "_ready_en_overlap"}, 64'(overlap), 64'(0));
    check({tag, "_idle_after_done"}, 64'(busy_after), 64'(0));
    check({tag, "_timeout"}, 64'(timeouts), 64'(0));
  endtask

  initial begin
    vectors = 0; miscompares = 0; timeouts = 0;
    pReset = 1'b0; start_a = 1'b0; start_e = 1'b0; abort = 1'b0;
    wr_valid = 1'b0; wr_data = '0; sel = 1'b0;
    load_a = 1'b0; load_e = 1'b0; load_val = '0;
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);

    // Reset state
    #12;
    check("reset_a", 64'({a_ready, a_head, a_en, a_rdv, a_busy, a_done, a_rd}), 64'(0));
    check("reset_e", 64'({e_ready, e_head, e_en, e_rdv, e_busy, e_done, e_rd}), 64'(0));
    @(negedge prog_clk);
    pReset = 1'b1;

    // V1: reset asserted while bit 13 is being shifted
    preload(1'b0, pattern_a5(N_A));
    @(negedge prog_clk);
    sel = 1'b0; start_a = 1'b1; wr_data = words[0]; wr_valid = 1'b1;
    @(negedge prog_clk);
    start_a = 1'b0;
    begin : v1
      int bits, guard, wi, activity;
      bits = 0; guard = 0; wi = 0; activity = 0;
      while (bits < 14 && guard < 200) begin
        if (a_en) bits++;
        if (bits < 14) begin
          wr_data = words[(wi < 8) ? wi : 7];
          if (a_ready) wi++;
          @(negedge prog_clk);
          guard++;
        end
      end
      check("v1_bit13_reached", 64'(bits), 64'(14));
      #2 pReset = 1'b0;
      #1;
      check("v1_async_outputs", 64'({a_ready, a_head, a_en, a_rdv, a_busy, a_done}), 64'(0));
      check("v1_async_rd_data", 64'(a_rd), 64'(0));
      @(negedge prog_clk);
      @(negedge prog_clk);
      pReset = 1'b1;
      for (int i = 0; i < 10; i++) begin
        wr_valid = 1'($urandom_range(0, 1));
        @(negedge prog_clk);
        if (a_busy || a_en || a_ready || a_rdv || a_done) activity++;
      end
      wr_valid = 1'b0;
      check("v1_idle_after_release", 64'(activity), 64'(0));
    end

    // V2 + V4: full load of 0x01..0x08; chain preloaded with 0xA5
    preload(1'b0, pattern_a5(N_A));
    run_load(1'b0, -1, 0, 1'b0, -1, -1);
    verify_full("v2", 1'b0, N_A);
    check("v2_done_at_67", 64'(done_cyc), 64'(67));
    for (int j = 0; j < 8; j++)
      check($sformatf("v4_rd%0d", j), 64'((j < rd_q.size()) ? rd_q[j] : 8'hxx),
            64'((j < 7) ? 8'hA5 : 8'h80));

    // V3: 5-cycle stall in FETCH of word 3
    preload(1'b0, pattern_a5(N_A));
    run_load(1'b0, 2, 5, 1'b0, -1, -1);
    verify_full("v3", 1'b0, N_A);
    check("v3_done_at_72", 64'(done_cyc), 64'(72));

    // V5: start during SHIFT is ignored; abort at bit 20; then a clean reload
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    preload(1'b0, N_A'({$urandom(), $urandom()}));
    run_load(1'b0, -1, 0, 1'b0, 20, 5);
    begin : v5
      logic [63:0] hv, sv;
      hv = '0; sv = '0;
      for (int k = 0; k < 21; k++) begin
        if (k < head_q.size()) hv[k] = head_q[k];
        sv[k] = stream_bit(k);
      end
      check("v5_en_before_abort", 64'(head_q.size()), 64'(21));
      check("v5_head_seq", hv, sv);
      check("v5_no_done", 64'(done_cnt), 64'(0));
      check("v5_quiet_after_abort", 64'(post_abort_bad), 64'(0));
      check("v5_rd_before_abort", 64'(rd_q.size()), 64'(2));
      check("v5_idle", 64'(busy_after), 64'(0));
    end
    run_load(1'b0, -1, 0, 1'b0, -1, -1);
    verify_full("v5_reload", 1'b0, N_A);

    // V6: CHAIN_LEN = WORD_W = 8
    words[0] = 8'($urandom);
    preload(1'b1, N_A'($urandom()));
    run_load(1'b1, -1, 0, 1'b0, -1, -1);
    verify_full("v6", 1'b1, N_E);
    check("v6_done_at_10", 64'(done_cyc), 64'(10));

    // Randomized loads with random stalls
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
      preload(1'b0, N_A'({$urandom(), $urandom()}));
      run_load(1'b0, -1, 0, 1'b1, -1, -1);
      verify_full($sformatf("rand_a%0d", r), 1'b0, N_A);
    end
    words[0] = 8'($urandom);
    preload(1'b1, N_A'($urandom()));
    run_load(1'b1, -1, 0, 1'b1, -1, -1);
    verify_full("rand_e", 1'b1, N_E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
